// File: rtl/fu_multicycle.sv
// WIDTH-bit function unit with registered result/flags and a start/done handshake.
// Classic ops commit in one cycle; N-bit shifts and unsigned multiply iterate.
module fu_multicycle #(
    parameter int WIDTH = 16,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {
        OP_SHR = 2'b00,
        OP_SHL = 2'b01,
        OP_ASR = 2'b10,
        OP_MUL = 2'b11
    } xop_t;

    state_t               state_q, state_d;
    xop_t                 op_q;
    logic [SW:0]          cnt_q;
    logic [2*WIDTH-1:0]   acc_q, step_acc;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH:0]       msum;
    logic                 step_c;
    logic [WIDTH-1:0]     addend, s_res;
    logic [WIDTH:0]       sum;
    logic                 s_v, s_c, s_nz, multi;
    logic [SW-1:0]        n;
    logic                 load, step, commit_s, commit_m;

    assign n    = B[SW-1:0];
    assign busy = (state_q == RUN);

    // Single-cycle result/flags from live inputs, and whether the op iterates
    always_comb begin
        addend = '0;
        sum    = '0;
        s_res  = '0;
        s_v    = 1'b0;
        s_c    = 1'b0;
        s_nz   = 1'b0;
        multi  = 1'b0;
        if (!FS[4]) begin
            if (!FS[3]) begin
                case (FS[2:1])
                    2'b00:   addend = '0;
                    2'b01:   addend = B;
                    2'b10:   addend = ~B;
                    default: addend = '1;
                endcase
                sum   = {1'b0, A} + {1'b0, addend} + {{WIDTH{1'b0}}, FS[0]};
                s_res = sum[WIDTH-1:0];
                s_c   = sum[WIDTH];
                s_v   = (A[WIDTH-1] == addend[WIDTH-1]) &&
                        (s_res[WIDTH-1] != A[WIDTH-1]);
                s_nz  = 1'b1;
            end else if (!FS[2]) begin
                case (FS[1:0])
                    2'b00:   s_res = A & B;
                    2'b01:   s_res = A | B;
                    2'b10:   s_res = A ^ B;
                    default: s_res = ~A;
                endcase
                s_nz = 1'b1;
            end else begin
                case (FS[1:0])
                    2'b00:   s_res = B;
                    2'b01:   s_res = B >> 1;
                    2'b10:   s_res = B << 1;
                    default: s_res = '0;
                endcase
            end
        end else if (FS[3:2] == 2'b00) begin
            if (FS[1:0] == 2'b11 || n != '0) begin
                multi = 1'b1;
            end else begin
                s_res = A;
                s_nz  = 1'b1;
            end
        end
    end

    // One iteration: single-bit shift, or one shift-add multiply step
    always_comb begin
        step_acc = acc_q;
        step_c   = 1'b0;
        msum     = '0;
        case (op_q)
            OP_SHR: begin
                step_acc[WIDTH-1:0] = {1'b0, acc_q[WIDTH-1:1]};
                step_c = acc_q[0];
            end
            OP_SHL: begin
                step_acc[WIDTH-1:0] = {acc_q[WIDTH-2:0], 1'b0};
                step_c = acc_q[WIDTH-1];
            end
            OP_ASR: begin
                step_acc[WIDTH-1:0] = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                step_c = acc_q[0];
            end
            default: begin
                msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       (acc_q[0] ? {1'b0, mcand_q} : '0);
                step_acc = {msum, acc_q[WIDTH-1:1]};
            end
        endcase
    end

    // Next-state and control strobes
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        commit_s = 1'b0;
        commit_m = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (multi) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        commit_s = 1'b1;
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == 1) begin
                    commit_m = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Working registers, committed outputs and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_SHR;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            done    <= 1'b0;
            result  <= '0;
            V       <= 1'b0;
            C       <= 1'b0;
            N       <= 1'b0;
            Z       <= 1'b0;
        end else begin
            done <= commit_s | commit_m;
            if (load) begin
                op_q    <= xop_t'(FS[1:0]);
                mcand_q <= A;
                if (FS[1:0] == OP_MUL) begin
                    cnt_q <= (SW+1)'(WIDTH);
                    acc_q <= {{WIDTH{1'b0}}, B};
                end else begin
                    cnt_q <= {1'b0, n};
                    acc_q <= {{WIDTH{1'b0}}, A};
                end
            end
            if (step) begin
                acc_q <= step_acc;
                cnt_q <= cnt_q - 1'b1;
            end
            if (commit_s) begin
                result <= s_res;
                V      <= s_v;
                C      <= s_c;
                N      <= s_nz & s_res[WIDTH-1];
                Z      <= s_nz & (s_res == '0);
            end
            if (commit_m) begin
                result <= step_acc[WIDTH-1:0];
                V      <= 1'b0;
                C      <= (op_q == OP_MUL) ?
                          (|step_acc[2*WIDTH-1:WIDTH]) : step_c;
                N      <= step_acc[WIDTH-1];
                Z      <= (step_acc[WIDTH-1:0] == '0);
            end
        end
    end
endmodule
